instruction_mem_responder: RTL and testbench

- Responder end of the instruction-fetch read interface. It accepts a single-cycle read request (`axi_read_txn` plus `axi_araddr`) from the instruction fetch FSM.
- It returns one 128-bit instruction line on `read_data`, qualified by a one-cycle `read_valid` pulse, followed by `read_done`.
- It holds the instruction table in internal line-wide storage. A host loads that storage through a 32-bit word write port.
- It sits between the host/CPU configuration path and the instruction fetcher that feeds the descriptor generator.

---
 rtl/instruction_mem_responder.sv | 143 ++++++++++++++
 tb/tb_instruction_mem_responder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_mem_responder.sv
// instruction_mem_responder
//   Responder end of the instruction-fetch read interface. A single-cycle read
//   request returns one 128-bit instruction line from internal line-wide
//   storage. The host loads that storage through a 32-bit word write port.
//
//   Optional build macro IMEM_OPCODE_CHECK_EN: when defined, every returned line
//   whose opcode field [127:125] is not segment (3'b101) or jump (3'b111) sets
//   err_code[3]. err_code is 4 bits wide in that build and 3 bits otherwise.
//
// Ports
//   clk           clock
//   rst           synchronous reset, active-high (storage is not cleared)
//   wr_en         host word write strobe
//   wr_addr[31:0] host byte address: [3:2] lane, [log2(DEPTH_LINES)+3:4] line
//   wr_data[31:0] host write word
//   axi_araddr    read byte address, sampled with axi_read_txn
//   axi_read_txn  single-cycle read request pulse
//   read_data     returned 128-bit line (lane 0 in [31:0])
//   read_valid    one-cycle pulse qualifying read_data
//   read_done     one-cycle pulse the cycle after read_valid
//   busy          high from request capture through the read_done cycle
//   err           OR of err_code
//   err_code      sticky causes: [0] misaligned, [1] out of range,
//                 [2] request dropped while busy, [3] bad opcode (optional)
module instruction_mem_responder #(
  parameter int unsigned DEPTH_LINES = 256,
  parameter int unsigned RD_LATENCY  = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [31:0]  wr_addr,
  input  logic [31:0]  wr_data,
  input  logic [31:0]  axi_araddr,
  input  logic         axi_read_txn,
  output logic [127:0] read_data,
  output logic         read_valid,
  output logic         read_done,
  output logic         busy,
  output logic         err,
`ifdef IMEM_OPCODE_CHECK_EN
  output logic [3:0]   err_code
`else
  output logic [2:0]   err_code
`endif
);

  localparam int unsigned LineW     = $clog2(DEPTH_LINES);
  localparam logic [31:0] ByteLimit = 32'(DEPTH_LINES * 16);
  localparam logic [3:0]  CntLoad   = 4'(RD_LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp, StDone} state_e;

  state_e      state_q;
  logic [31:0] addr_q;
  logic [3:0]  cnt_q;

  // Line storage, one 32-bit lane per element; deliberately has no reset.
  logic [3:0][31:0] mem_q [DEPTH_LINES];

  logic [LineW-1:0] rd_line;
  logic             rd_oor;
  logic             rd_misaligned;
  logic [LineW-1:0] wr_line;
  logic [1:0]       wr_lane;
  logic             wr_in_range;
  logic             unused_wr_addr;

  assign rd_line        = addr_q[LineW+3:4];
  assign rd_oor         = (addr_q >= ByteLimit);
  assign rd_misaligned  = |addr_q[3:0];
  assign wr_line        = wr_addr[LineW+3:4];
  assign wr_lane        = wr_addr[3:2];
  assign wr_in_range    = (wr_addr < ByteLimit);
  assign unused_wr_addr = ^wr_addr[1:0];

  assign err = |err_code;

  // Host writes land every cycle. Because the FSM read below samples mem_q at
  // the same edge, a same-cycle write to the line being read returns old data.
  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range) begin
      mem_q[wr_line][wr_lane] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      cnt_q      <= '0;
      read_data  <= '0;
      read_valid <= 1'b0;
      read_done  <= 1'b0;
      busy       <= 1'b0;
      err_code   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (axi_read_txn) begin
            addr_q  <= axi_araddr;
            cnt_q   <= CntLoad;
            busy    <= 1'b1;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            read_data  <= rd_oor ? '0 : mem_q[rd_line];
            read_valid <= 1'b1;
            state_q    <= StResp;
            if (rd_misaligned) err_code[0] <= 1'b1;
            if (rd_oor)        err_code[1] <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          read_valid <= 1'b0;
          read_done  <= 1'b1;
          state_q    <= StDone;
`ifdef IMEM_OPCODE_CHECK_EN
          if ((read_data[127:125] != 3'b101) && (read_data[127:125] != 3'b111)) begin
            err_code[3] <= 1'b1;
          end
`endif
        end
        StDone: begin
          read_done <= 1'b0;
          busy      <= 1'b0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      // Any request arriving outside IDLE is dropped without a response.
      if (axi_read_txn && (state_q != StIdle)) begin
        err_code[2] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instruction_mem_responder.sv
module tb_instruction_mem_responder;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned LAT   = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en;
  logic [31:0]  wr_addr;
  logic [31:0]  wr_data;
  logic [31:0]  axi_araddr;
  logic         axi_read_txn;
  logic [127:0] read_data;
  logic         read_valid;
  logic         read_done;
  logic         busy;
  logic         err;
  logic [2:0]   err_code;

  instruction_mem_responder #(
    .DEPTH_LINES(DEPTH),
    .RD_LATENCY (LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .axi_araddr  (axi_araddr),
    .axi_read_txn(axi_read_txn),
    .read_data   (read_data),
    .read_valid  (read_valid),
    .read_done   (read_done),
    .busy        (busy),
    .err         (err),
    .err_code    (err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] data;
    int           cyc;
  } exp_t;

  typedef struct {
    logic [31:0]  addr;
    logic [127:0] data;
    logic [2:0]   err;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[8];
  int   n_vec      = 0;
  int   n_bad      = 0;
  int   valid_seen = 0;
  int   exp_total  = 0;
  logic prev_valid = 1'b0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Response monitor: pops the scoreboard on each read_valid.
  always @(negedge clk) begin
    if (!rst) begin
      if (read_valid) begin
        valid_seen++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_valid: got read_valid=1 data %h, want no response (cycle %0d)",
                   read_data, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("read_data", read_data, e.data);
          check("valid_cycle", 128'(cyc), 128'(e.cyc));
        end
      end
      if (read_done) check("done_after_valid", 128'(prev_valid), 128'(1));
      prev_valid = read_valid;
    end
  end

  task automatic write_word(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic push_exp(input logic [127:0] d, input int t);
    exp_t e;
    e.data = d;
    e.cyc  = t + LAT + 1;
    exp_q.push_back(e);
    exp_total++;
  endtask

  task automatic check_outputs_zero();
    check("rst_read_data", read_data, '0);
    check("rst_flags", {124'd0, read_valid, read_done, busy, err}, '0);
    check("rst_err_code", 128'(err_code), '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero();
    rst = 1'b0;
  endtask

  // Waits for busy to fall; it must first be low at T+LAT+3.
  task automatic wait_idle(input int t);
    int k = 0;
    while (busy && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      n_vec++;
      n_bad++;
      $display("FAIL busy_timeout: got busy=1 after 40 cycles, want 0");
    end else begin
      check("busy_fall_cycle", 128'(cyc), 128'(t + LAT + 3));
    end
  endtask

  task automatic do_read(input logic [31:0] a, input logic [127:0] d, input logic [2:0] e);
    int t;
    @(negedge clk);
    axi_read_txn = 1'b1;
    axi_araddr   = a;
    t = cyc;
    push_exp(d, t);
    @(negedge clk);
    axi_read_txn = 1'b0;
    check("busy_on_capture", 128'(busy), 128'(1));
    wait_idle(t);
    check("err_code", 128'(err_code), 128'(e));
    check("err", 128'(err), 128'(e != 3'b000));
  endtask

  localparam logic [127:0] Line0 = {32'hE0000040, 32'h00000030, 32'h00000020, 32'h00000010};
  localparam logic [127:0] Line2 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
  localparam logic [127:0] Line5 = {32'hA1B2C3D4, 32'h0BADF00D, 32'h9ABCDEF0, 32'h12345678};
  localparam logic [127:0] LineL = {32'hF0F0F0F0, 32'h0F0F0F0F, 32'h5A5A5A5A, 32'hA5A5A5A5};

  initial begin
    int t;
    logic [127:0] l2;

    vecs[0] = '{32'h0000_0020, Line2, 3'b000};
    vecs[1] = '{32'h0000_0000, Line0, 3'b000};
    vecs[2] = '{32'h0000_0FF0, LineL, 3'b000};
    vecs[3] = '{32'h0000_0050, Line5, 3'b000};
    vecs[4] = '{32'h0000_0024, Line2, 3'b001};
    vecs[5] = '{32'h0000_005F, Line5, 3'b001};
    vecs[6] = '{32'h0000_1000, '0,    3'b011};
    vecs[7] = '{32'hFFFF_FFF0, '0,    3'b011};

    rst          = 1'b1;
    wr_en        = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;
    axi_araddr   = '0;
    axi_read_txn = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs_zero();
    rst = 1'b0;

    write_word(32'h20, 32'h11111111);
    write_word(32'h24, 32'h22222222);
    write_word(32'h28, 32'h33333333);
    write_word(32'h2C, 32'h44444444);
    write_word(32'h00, 32'h00000010);
    write_word(32'h04, 32'h00000020);
    write_word(32'h08, 32'h00000030);
    write_word(32'h0C, 32'hE0000040);
    write_word(32'h1000, 32'hDEADBEEF);  // out of range; would alias line 0 lane 0
    write_word(32'hFF0, 32'hA5A5A5A5);
    write_word(32'hFF4, 32'h5A5A5A5A);
    write_word(32'hFF8, 32'h0F0F0F0F);
    write_word(32'hFFC, 32'hF0F0F0F0);
    write_word(32'h53, 32'h12345678);    // byte offset ignored -> lane 0 of line 5
    write_word(32'h54, 32'h9ABCDEF0);
    write_word(32'h58, 32'h0BADF00D);
    write_word(32'h5C, 32'hA1B2C3D4);

    for (int i = 0; i < 8; i++) do_read(vecs[i].addr, vecs[i].data, vecs[i].err);

    // Single-lane update leaves the other lanes alone.
    write_word(32'h24, 32'hCAFEF00D);
    l2 = {32'h44444444, 32'h33333333, 32'hCAFEF00D, 32'h11111111};
    do_read(32'h20, l2, 3'b011);

    // Request during a transaction is dropped.
    do_reset();
    @(negedge clk);
    axi_read_txn = 1'b1;
    axi_araddr   = 32'h20;
    t = cyc;
    push_exp(l2, t);
    @(negedge clk);
    axi_read_txn = 1'b0;
    @(negedge clk);
    axi_read_txn = 1'b1;
    axi_araddr   = 32'h00;
    @(negedge clk);
    axi_read_txn = 1'b0;
    wait_idle(t);
    check("drop_err_code", 128'(err_code), 128'(3'b100));
    check("drop_err", 128'(err), 128'(1));
    do_read(32'h00, Line0, 3'b100);

    // Write in an earlier WAIT cycle is visible.
    do_reset();
    l2 = {32'h44444444, 32'h33333333, 32'hCAFEF00D, 32'h77777777};
    @(negedge clk);
    axi_read_txn = 1'b1;
    axi_araddr   = 32'h20;
    t = cyc;
    push_exp(l2, t);
    @(negedge clk);
    axi_read_txn = 1'b0;
    wr_en   = 1'b1;
    wr_addr = 32'h20;
    wr_data = 32'h77777777;
    @(negedge clk);
    wr_en = 1'b0;
    wait_idle(t);

    // Write in the storage-read cycle returns the old line.
    @(negedge clk);
    axi_read_txn = 1'b1;
    axi_araddr   = 32'h20;
    t = cyc;
    push_exp(l2, t);
    @(negedge clk);
    axi_read_txn = 1'b0;
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = 32'h2C;
    wr_data = 32'hA0000000;
    @(negedge clk);
    wr_en = 1'b0;
    wait_idle(t);
    l2 = {32'hA0000000, 32'h33333333, 32'hCAFEF00D, 32'h77777777};
    do_read(32'h20, l2, 3'b000);

    // Reset in the middle of a transaction aborts it.
    @(negedge clk);
    axi_read_txn = 1'b1;
    axi_araddr   = 32'h00;
    @(negedge clk);
    axi_read_txn = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero();
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_busy", 128'(busy), 128'(0));
    do_read(32'h20, l2, 3'b000);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    check("valid_count", 128'(valid_seen), 128'(exp_total));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
